// File: rtl/dm_access_arbiter_if.sv
// Request/response bundle for one data-memory requester (CPU load/store or debug/loader).
// The requester drives the master side and the arbiter sits on the slave side.
interface dm_access_arbiter_if #(
    parameter int unsigned ADDR_W = 6
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        atype;
    logic [31:0]       wdata;
    logic              ack;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, atype, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, atype, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// Shares a single-port, registered-read data memory between the CPU and debug ports.
// One request in flight at a time: IDLE picks and checks, ACCESS drives memory, RESP acks.
module dm_access_arbiter #(
    parameter int unsigned ADDR_W     = 6,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    dm_access_arbiter_if.slave  cpu,
    dm_access_arbiter_if.slave  dbg,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [2:0]          mem_type,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic                busy
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [2:0] TypeW  = 3'b000;
    localparam logic [2:0] TypeH  = 3'b001;
    localparam logic [2:0] TypeHu = 3'b010;
    localparam logic [2:0] TypeB  = 3'b011;
    localparam logic [2:0] TypeBu = 3'b100;

    function automatic logic access_legal(input logic we, input logic [2:0] t,
                                          input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (t)
            TypeW:   ok = (a == 2'b00);
            TypeH:   ok = ~a[0];
            TypeHu:  ok = ~a[0] & ~we;
            TypeB:   ok = 1'b1;
            TypeBu:  ok = ~we;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The memory only understands W/H/B; unsigned variants differ only in extension here.
    function automatic logic [2:0] issue_type(input logic [2:0] t);
        logic [2:0] r;
        r = t;
        case (t)
            TypeHu:  r = TypeH;
            TypeBu:  r = TypeB;
            default: r = t;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] t);
        logic [31:0] v;
        v = d;
        case (t)
            TypeH:   v = {{16{d[15]}}, d[15:0]};
            TypeHu:  v = {16'h0000, d[15:0]};
            TypeBu:  v = {24'h000000, d[7:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    state_e            state_q, state_d;
    logic              last_dbg_q, last_dbg_d;
    logic              gnt_dbg_q, gnt_dbg_d;
    logic              op_we_q, op_we_d;
    logic [2:0]        op_type_q, op_type_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        mem_type_q, mem_type_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_err_q, cpu_err_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              dbg_err_q, dbg_err_d;

    logic              any_req;
    logic              pick_dbg;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_type;
    logic [31:0]       sel_wdata;
    logic              sel_legal;
    logic [31:0]       load_data;

    // On a tie, round-robin favours whichever port was not granted last.
    assign any_req   = cpu.req | dbg.req;
    assign pick_dbg  = dbg.req & (~cpu.req | (!FIXED_PRIO & ~last_dbg_q));
    assign sel_we    = pick_dbg ? dbg.we    : cpu.we;
    assign sel_addr  = pick_dbg ? dbg.addr  : cpu.addr;
    assign sel_type  = pick_dbg ? dbg.atype : cpu.atype;
    assign sel_wdata = pick_dbg ? dbg.wdata : cpu.wdata;
    assign sel_legal = access_legal(sel_we, sel_type, sel_addr[1:0]);

    always_comb begin
        state_d     = state_q;
        last_dbg_d  = last_dbg_q;
        gnt_dbg_d   = gnt_dbg_q;
        op_we_d     = op_we_q;
        op_type_d   = op_type_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_type_d  = mem_type_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        dbg_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_dbg_d  = pick_dbg;
                    last_dbg_d = pick_dbg;
                    op_we_d    = sel_we;
                    op_type_d  = sel_type;
                    if (sel_legal) begin
                        state_d     = StAccess;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_addr;
                        mem_type_d  = issue_type(sel_type);
                        mem_wdata_d = sel_wdata;
                    end else begin
                        // Rejected requests skip the memory and respond with err next cycle.
                        state_d   = StResp;
                        cpu_ack_d = ~pick_dbg;
                        cpu_err_d = ~pick_dbg;
                        dbg_ack_d = pick_dbg;
                        dbg_err_d = pick_dbg;
                    end
                end
            end
            StAccess: begin
                state_d   = StResp;
                cpu_ack_d = ~gnt_dbg_q;
                dbg_ack_d = gnt_dbg_q;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_dbg_q  <= 1'b1;
            gnt_dbg_q   <= 1'b0;
            op_we_q     <= 1'b0;
            op_type_q   <= 3'b000;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_type_q  <= 3'b000;
            mem_wdata_q <= 32'h0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dbg_q  <= last_dbg_d;
            gnt_dbg_q   <= gnt_dbg_d;
            op_we_q     <= op_we_d;
            op_type_q   <= op_type_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_type_q  <= mem_type_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_err_q   <= dbg_err_d;
        end
    end

    // Read data only exists in the RESP cycle, so rdata is the extended memory output gated by ack.
    assign load_data = extend_load(mem_rdata, op_type_q);

    assign cpu.ack   = cpu_ack_q;
    assign cpu.err   = cpu_err_q;
    assign cpu.rdata = (cpu_ack_q & ~cpu_err_q & ~op_we_q) ? load_data : 32'h0;
    assign dbg.ack   = dbg_ack_q;
    assign dbg.err   = dbg_err_q;
    assign dbg.rdata = (dbg_ack_q & ~dbg_err_q & ~op_we_q) ? load_data : 32'h0;

    // A reset landing on the ACCESS cycle must not let the write reach the memory edge.
    assign mem_we    = mem_we_q & ~rst;
    assign mem_addr  = mem_addr_q;
    assign mem_type  = mem_type_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle);
endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: byte-array reference model, per-port expectation queues
// popped by a monitor on each ack, directed corner cases plus randomized traffic.
module tb_dm_access_arbiter;
    localparam int unsigned AW = 6;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic pre_en;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    int   mem_we_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_access_arbiter_if #(.ADDR_W(AW)) cpu_if ();
    dm_access_arbiter_if #(.ADDR_W(AW)) dbg_if ();
    dm_access_arbiter_if #(.ADDR_W(AW)) fp_cpu_if ();
    dm_access_arbiter_if #(.ADDR_W(AW)) fp_dbg_if ();

    logic          mem_we, fp_mem_we;
    logic [AW-1:0] mem_addr, fp_mem_addr;
    logic [2:0]    mem_type, fp_mem_type;
    logic [31:0]   mem_wdata, fp_mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   fp_mem_rdata;
    logic          busy, fp_busy;

    assign fp_mem_rdata = 32'h0;

    dm_access_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst), .cpu(cpu_if), .dbg(dbg_if),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_type(mem_type), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dm_access_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .cpu(fp_cpu_if), .dbg(fp_dbg_if),
        .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_type(fp_mem_type),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    function automatic int nbytes(input logic [2:0] t);
        return (t == 3'd0) ? 4 : ((t < 3'd3) ? 2 : 1);
    endfunction

    // Physical RAM: registered read, H and B come back sign-extended.
    logic [7:0] phys_mem [64];

    function automatic logic [31:0] phys_read(input logic [AW-1:0] a, input logic [2:0] t);
        logic [7:0] b0, b1, b2, b3;
        b0 = phys_mem[(int'(a) + 0) % 64];
        b1 = phys_mem[(int'(a) + 1) % 64];
        b2 = phys_mem[(int'(a) + 2) % 64];
        b3 = phys_mem[(int'(a) + 3) % 64];
        case (t)
            3'b000:  return {b3, b2, b1, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b011:  return {{24{b0[7]}}, b0};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 64; i++) phys_mem[i] <= init_byte(i);
        end else if (mem_we) begin
            for (int i = 0; i < nbytes(mem_type); i++)
                phys_mem[(int'(mem_addr) + i) % 64] <= mem_wdata[8*i +: 8];
        end
        mem_rdata <= phys_read(mem_addr, mem_type);
    end

    // Reference model: plain byte array updated in program order per port.
    logic [7:0] ref_mem [64];

    function automatic bit model_legal(input bit we, input logic [2:0] t, input logic [5:0] a);
        case (t)
            3'd0:    return a[1:0] == 2'b00;
            3'd1:    return !a[0];
            3'd2:    return !we && !a[0];
            3'd3:    return 1'b1;
            3'd4:    return !we;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] a, input logic [2:0] t);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < nbytes(t); i++) v = v | (32'(ref_mem[(int'(a) + i) % 64]) << (8 * i));
        if (t == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        if (t == 3'd3 && v[7]) v = v | 32'hFFFFFF00;
        return v;
    endfunction

    function automatic void model_store(input logic [5:0] a, input logic [2:0] t,
                                        input logic [31:0] wd);
        for (int i = 0; i < nbytes(t); i++) ref_mem[(int'(a) + i) % 64] = wd[8*i +: 8];
    endfunction

    exp_t q_cpu[$];
    exp_t q_dbg[$];
    exp_t mon_c, mon_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) mem_we_cnt++;
        if (cpu_if.ack) begin
            if (q_cpu.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpu_unexpected_ack actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_c = q_cpu.pop_front();
                chk("cpu_err", 32'(cpu_if.err), 32'(mon_c.err));
                chk("cpu_rdata", cpu_if.rdata, mon_c.rdata);
                chk("dbg_quiet", dbg_if.rdata | {30'h0, dbg_if.ack, dbg_if.err}, 32'h0);
            end
        end
        if (dbg_if.ack) begin
            if (q_dbg.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dbg_unexpected_ack actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_d = q_dbg.pop_front();
                chk("dbg_err", 32'(dbg_if.err), 32'(mon_d.err));
                chk("dbg_rdata", dbg_if.rdata, mon_d.rdata);
                chk("cpu_quiet", cpu_if.rdata | {30'h0, cpu_if.ack, cpu_if.err}, 32'h0);
            end
        end
    end

    task automatic set_port(input bit p, input bit rq, input bit we, input logic [5:0] a,
                            input logic [2:0] t, input logic [31:0] wd);
        if (p) begin
            dbg_if.req = rq; dbg_if.we = we; dbg_if.addr = a; dbg_if.atype = t;
            dbg_if.wdata = wd;
        end else begin
            cpu_if.req = rq; cpu_if.we = we; cpu_if.addr = a; cpu_if.atype = t;
            cpu_if.wdata = wd;
        end
    endtask

    // Called at a negedge; returns at the negedge where ack was observed.
    task automatic issue(input bit p, input bit we, input logic [5:0] a, input logic [2:0] t,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int ack_cyc);
        exp_t e;
        e.err   = !model_legal(we, t, a);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) model_store(a, t, wd);
            else e.rdata = model_load(a, t);
        end
        if (p) q_dbg.push_back(e);
        else q_cpu.push_back(e);
        set_port(p, 1'b1, we, a, t, wd);
        lat = 0; rd = 32'h0; er = 1'b0; ack_cyc = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (p ? dbg_if.ack : cpu_if.ack) begin
                lat = i;
                rd = p ? dbg_if.rdata : cpu_if.rdata;
                er = p ? dbg_if.err : cpu_if.err;
                ack_cyc = cyc;
                break;
            end
        end
        set_port(p, 1'b0, 1'b0, 6'h00, 3'd0, 32'h0);
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port=%0d actual=none required=ack within 12 cycles", p);
        end
    endtask

    task automatic rand_port(input bit p, input logic [5:0] base, input int cnt);
        bit          we;
        logic [2:0]  t;
        logic [5:0]  a;
        logic [31:0] wd, rd;
        logic        er;
        int          lat, ac;
        for (int n = 0; n < cnt; n++) begin
            we = bit'($urandom % 2);
            t  = 3'($urandom % 6);
            a  = base + 6'($urandom % 32);
            if ($urandom % 4 != 0) begin
                if (t == 3'd0) a[1:0] = 2'b00;
                else if (t < 3'd3) a[0] = 1'b0;
            end
            wd = $urandom;
            issue(p, we, a, t, wd, rd, er, lat, ac);
            repeat ($urandom % 3) @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd_a, rd_b, rd_c, old_val;
    logic        er_a, er_b, er_c;
    int          lat_a, lat_b, lat_c, cy_a, cy_b, cy_c, we_snap, ca, da;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
        set_port(1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 6'h00, 3'd0, 32'h0);
        fp_cpu_if.req = 0; fp_cpu_if.we = 0; fp_cpu_if.addr = 0; fp_cpu_if.atype = 0;
        fp_cpu_if.wdata = 0;
        fp_dbg_if.req = 0; fp_dbg_if.we = 0; fp_dbg_if.addr = 0; fp_dbg_if.atype = 0;
        fp_dbg_if.wdata = 0;
        rst = 1'b1;
        pre_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_acks", {28'h0, cpu_if.ack, cpu_if.err, dbg_if.ack, dbg_if.err}, 32'h0);
        chk("rst_cpu_rdata", cpu_if.rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_if.rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_type", 32'(mem_type), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        pre_en = 1'b0;
        @(negedge clk);

        // Tie right after reset: CPU first, then debug, then CPU's immediate re-request.
        fork
            begin
                issue(1'b0, 1'b0, 6'h00, 3'd0, 32'h0, rd_a, er_a, lat_a, cy_a);
                issue(1'b0, 1'b0, 6'h04, 3'd0, 32'h0, rd_c, er_c, lat_c, cy_c);
            end
            issue(1'b1, 1'b0, 6'h20, 3'd0, 32'h0, rd_b, er_b, lat_b, cy_b);
        join
        chk("rr_cpu_first_latency", 32'(lat_a), 32'd2);
        chk("rr_dbg_after_cpu", 32'(cy_b - cy_a), 32'd3);
        chk("rr_cpu_after_dbg", 32'(cy_c - cy_b), 32'd3);

        @(negedge clk);
        issue(1'b0, 1'b1, 6'h08, 3'd0, 32'hDEADBEEF, rd_a, er_a, lat_a, cy_a);
        chk("store_w_latency", 32'(lat_a), 32'd2);
        @(negedge clk);
        issue(1'b0, 1'b0, 6'h08, 3'd0, 32'h0, rd_a, er_a, lat_a, cy_a);
        chk("load_w_latency", 32'(lat_a), 32'd2);
        chk("load_w_value", rd_a, 32'hDEADBEEF);
        chk("load_w_err", 32'(er_a), 32'h0);

        @(negedge clk);
        issue(1'b0, 1'b1, 6'h11, 3'd3, 32'h00000080, rd_a, er_a, lat_a, cy_a);
        @(negedge clk);
        issue(1'b0, 1'b0, 6'h11, 3'd3, 32'h0, rd_a, er_a, lat_a, cy_a);
        chk("load_b_sext", rd_a, 32'hFFFFFF80);
        issue(1'b0, 1'b0, 6'h11, 3'd4, 32'h0, rd_a, er_a, lat_a, cy_a);
        chk("load_bu_zext", rd_a, 32'h00000080);
        issue(1'b0, 1'b1, 6'h12, 3'd1, 32'h00008001, rd_a, er_a, lat_a, cy_a);
        issue(1'b0, 1'b0, 6'h12, 3'd2, 32'h0, rd_a, er_a, lat_a, cy_a);
        chk("load_hu_zext", rd_a, 32'h00008001);
        issue(1'b0, 1'b0, 6'h12, 3'd1, 32'h0, rd_a, er_a, lat_a, cy_a);
        chk("load_h_sext", rd_a, 32'hFFFF8001);

        @(negedge clk);
        we_snap = mem_we_cnt;
        issue(1'b0, 1'b0, 6'h0A, 3'd0, 32'h0, rd_a, er_a, lat_a, cy_a);
        chk("misaligned_w_err", 32'(er_a), 32'h1);
        issue(1'b1, 1'b0, 6'h03, 3'd1, 32'h0, rd_a, er_a, lat_a, cy_a);
        chk("misaligned_h_err", 32'(er_a), 32'h1);
        issue(1'b0, 1'b1, 6'h00, 3'd4, 32'h11223344, rd_a, er_a, lat_a, cy_a);
        chk("store_bu_err", 32'(er_a), 32'h1);
        chk("store_bu_rdata", rd_a, 32'h0);
        chk("illegal_no_mem_we", 32'(mem_we_cnt - we_snap), 32'h0);
        issue(1'b0, 1'b0, 6'h00, 3'd0, 32'h0, rd_a, er_a, lat_a, cy_a);

        // Reset lands on the ACCESS cycle of a store: no write, no ack.
        @(negedge clk);
        old_val = model_load(6'h20, 3'd0);
        set_port(1'b0, 1'b1, 1'b1, 6'h20, 3'd0, 32'h12345678);
        @(negedge clk);
        chk("abort_busy_in_access", 32'(busy), 32'h1);
        chk("abort_mem_we_before_rst", 32'(mem_we), 32'h1);
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 32'h0);
        #1;
        chk("abort_mem_we_gated", 32'(mem_we), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_idle", 32'(busy), 32'h0);
        chk("abort_no_ack", 32'(cpu_if.ack), 32'h0);
        repeat (4) @(negedge clk);
        issue(1'b0, 1'b0, 6'h20, 3'd0, 32'h0, rd_a, er_a, lat_a, cy_a);
        chk("abort_old_value", rd_a, old_val);

        @(negedge clk);
        fork
            rand_port(1'b0, 6'h00, 60);
            rand_port(1'b1, 6'h20, 60);
        join
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q_cpu.size() + q_dbg.size()), 32'h0);

        // Fixed priority: CPU requesting continuously starves debug.
        ca = 0;
        da = 0;
        fp_cpu_if.req = 1'b1;
        fp_dbg_if.req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fp_cpu_if.ack) ca++;
            if (fp_dbg_if.ack) da++;
        end
        chk("fixed_cpu_acks", 32'(ca), 32'd10);
        chk("fixed_dbg_starved", 32'(da), 32'd0);
        fp_cpu_if.req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fp_dbg_if.ack) begin
                da++;
                break;
            end
        end
        fp_dbg_if.req = 1'b0;
        chk("fixed_dbg_after_release", 32'(da), 32'd1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
